// File: rtl/ebw_down_ctrl.sv
// ebw_down_ctrl: holds one wide word and replays it as RATIO narrow beats, LSB slice first.
// Build option EBW_DOWN_CTRL_BYPASS_EN lets the next word load on the last-beat handshake.
module ebw_down_ctrl #(
  parameter  int DW    = 8,
  parameter  int RATIO = 4,
  localparam int CW    = $clog2(RATIO)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                t_0_req,
  output logic                t_0_ack,
  input  logic [DW*RATIO-1:0] t_0_dat,
  output logic                i_0_req,
  input  logic                i_0_ack,
  output logic [DW-1:0]       i_0_dat,
  output logic                i_0_last
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_SEND  = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_next;
  logic [DW*RATIO-1:0]   r_word;
  logic [DW*RATIO-1:0]   w_word_next;
  logic                  w_full;
  logic                  w_at_last;
  logic                  w_t_x;
  logic                  w_i_x;
  logic [DW-1:0]         w_slice [RATIO];

  // Beat view of the held word; the counter selects which slice is presented.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
      assign w_slice[gi] = r_word[gi*DW +: DW];
    end
  endgenerate

  assign w_full    = (r_state == S_SEND);
  assign w_at_last = (r_cnt == LAST_CNT);
  assign w_t_x     = t_0_req & t_0_ack;
  assign w_i_x     = i_0_req & i_0_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A load can only coincide with the last beat in the bypass build, so one rule serves both.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_EMPTY: if (w_t_x) w_state_next = S_SEND;
      S_SEND:  if (w_i_x && w_at_last) w_state_next = w_t_x ? S_SEND : S_EMPTY;
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_comb begin
    i_0_req  = w_full;
    i_0_last = w_full & w_at_last;
    i_0_dat  = w_slice[r_cnt];
`ifdef EBW_DOWN_CTRL_BYPASS_EN
    t_0_ack  = ~w_full | (i_0_ack & w_full & w_at_last);
`else
    t_0_ack  = ~w_full;
`endif
  end

  always_comb begin
    w_word_next = r_word;
    w_cnt_next  = r_cnt;
    if (w_t_x) begin
      w_word_next = t_0_dat;
      w_cnt_next  = '0;
    end else if (w_i_x) begin
      w_cnt_next  = w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else begin
      r_word <= w_word_next;
      r_cnt  <= w_cnt_next;
    end
  end

endmodule

// File: tb/tb_ebw_down_ctrl.sv
// tb_ebw_down_ctrl: directed vector table, hand sequences and a random scoreboard run.
// Honours EBW_DOWN_CTRL_BYPASS_EN for the build-dependent expectations.
module tb_ebw_down_ctrl;
  localparam int DW    = 8;
  localparam int RATIO = 4;
`ifdef EBW_DOWN_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        t_0_req = 1'b0;
  logic        t_0_ack;
  logic [31:0] t_0_dat = '0;
  logic        i_0_req;
  logic        i_0_ack = 1'b0;
  logic [7:0]  i_0_dat;
  logic        i_0_last;

  int n_vec = 0;
  int n_err = 0;

  ebw_down_ctrl #(.DW(DW), .RATIO(RATIO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .t_0_req  (t_0_req),
    .t_0_ack  (t_0_ack),
    .t_0_dat  (t_0_dat),
    .i_0_req  (i_0_req),
    .i_0_ack  (i_0_ack),
    .i_0_dat  (i_0_dat),
    .i_0_last (i_0_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input bit tr, input logic [31:0] td, input bit ia);
    @(negedge clk);
    t_0_req = tr;
    t_0_dat = td;
    i_0_ack = ia;
    #1;
  endtask

  typedef struct {
    bit          tr;
    logic [31:0] td;
    bit          ia;
    bit          ta;
    bit          ta_byp;
    bit          rq;
    logic [7:0]  d;
    bit          ls;
  } vec_t;

  vec_t tbl [17];

  logic [7:0] q_d [$];
  bit         q_l [$];

  task automatic rnd_check();
    bit exp_tack;
    exp_tack = (q_d.size() == 0) || (BYP && i_0_ack && q_d.size() == 1);
    chk("rnd i_0_req", i_0_req, (q_d.size() != 0));
    chk("rnd t_0_ack", t_0_ack, exp_tack);
    if (i_0_req && q_d.size() != 0) begin
      chk("rnd i_0_dat", i_0_dat, q_d[0]);
      chk("rnd i_0_last", i_0_last, q_l[0]);
      if (i_0_ack) begin
        void'(q_d.pop_front());
        void'(q_l.pop_front());
      end
    end
    if (t_0_req && t_0_ack) begin
      for (int b = 0; b < RATIO; b++) begin
        q_d.push_back(t_0_dat[b*8 +: 8]);
        q_l.push_back(b == RATIO - 1);
      end
    end
  endtask

  initial begin
    logic [31:0] sw [3];
    logic [31:0] w;
    int wi, nb, first_c, last_c;

    //         tr  td            ia ta tab rq d      ls
    tbl[0]  = '{1, 32'hDDCCBBAA, 1, 1, 1, 0, 8'h00, 0};
    tbl[1]  = '{0, 32'h00000000, 1, 0, 0, 1, 8'hAA, 0};
    tbl[2]  = '{0, 32'h00000000, 1, 0, 0, 1, 8'hBB, 0};
    tbl[3]  = '{0, 32'h00000000, 1, 0, 0, 1, 8'hCC, 0};
    tbl[4]  = '{0, 32'h00000000, 1, 0, 1, 1, 8'hDD, 1};
    tbl[5]  = '{0, 32'h00000000, 1, 1, 1, 0, 8'h00, 0};
    tbl[6]  = '{1, 32'h44332211, 0, 1, 1, 0, 8'h00, 0};
    tbl[7]  = '{1, 32'hFFFFFFFF, 1, 0, 0, 1, 8'h11, 0};
    tbl[8]  = '{1, 32'hFFFFFFFF, 0, 0, 0, 1, 8'h22, 0};
    tbl[9]  = '{1, 32'hFFFFFFFF, 0, 0, 0, 1, 8'h22, 0};
    tbl[10] = '{1, 32'hFFFFFFFF, 0, 0, 0, 1, 8'h22, 0};
    tbl[11] = '{1, 32'hFFFFFFFF, 0, 0, 0, 1, 8'h22, 0};
    tbl[12] = '{1, 32'hFFFFFFFF, 0, 0, 0, 1, 8'h22, 0};
    tbl[13] = '{1, 32'hFFFFFFFF, 1, 0, 0, 1, 8'h22, 0};
    tbl[14] = '{1, 32'hFFFFFFFF, 1, 0, 0, 1, 8'h33, 0};
    tbl[15] = '{0, 32'h00000000, 1, 0, 1, 1, 8'h44, 1};
    tbl[16] = '{0, 32'h00000000, 0, 1, 1, 0, 8'h00, 0};

    // Reset held with an upstream request pending.
    t_0_req = 1'b1;
    t_0_dat = 32'hDDCCBBAA;
    i_0_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset t_0_ack", t_0_ack, 1);
    chk("reset i_0_req", i_0_req, 0);
    chk("reset i_0_dat", i_0_dat, 0);
    chk("reset i_0_last", i_0_last, 0);
    t_0_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].tr, tbl[k].td, tbl[k].ia);
      chk($sformatf("v%0d t_0_ack", k), t_0_ack, BYP ? tbl[k].ta_byp : tbl[k].ta);
      chk($sformatf("v%0d i_0_req", k), i_0_req, tbl[k].rq);
      chk($sformatf("v%0d i_0_last", k), i_0_last, tbl[k].ls);
      if (tbl[k].rq) chk($sformatf("v%0d i_0_dat", k), i_0_dat, tbl[k].d);
    end

    // Streaming three words with the sink always ready.
    sw[0] = 32'h03020100;
    sw[1] = 32'h13121110;
    sw[2] = 32'h23222120;
    wi = 0; nb = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 40 && nb < 12; c++) begin
      drive(wi < 3, sw[wi % 3], 1'b1);
      if (i_0_req) begin
        w = sw[nb / 4];
        chk("stream i_0_dat", i_0_dat, w[(nb % 4)*8 +: 8]);
        chk("stream i_0_last", i_0_last, (nb % 4) == 3);
        nb++;
        last_c = c;
      end
      if (t_0_req && t_0_ack) begin
        if (first_c < 0) first_c = c;
        wi++;
      end
    end
    chk("stream beats", nb, 12);
    chk("stream span", last_c - first_c + 1, BYP ? 13 : 15);
    drive(0, 0, 0);
    chk("stream idle i_0_req", i_0_req, 0);

    // Reset pulse mid-word discards the remaining beats.
    drive(1, 32'hDDCCBBAA, 0);
    chk("rst5 load t_0_ack", t_0_ack, 1);
    drive(0, 0, 1);
    chk("rst5 beat0", i_0_dat, 8'hAA);
    drive(0, 0, 1);
    chk("rst5 beat1", i_0_dat, 8'hBB);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst5 in reset i_0_req", i_0_req, 0);
    chk("rst5 in reset t_0_ack", t_0_ack, 1);
    #2;
    reset_n = 1'b1;
    drive(0, 0, 1);
    chk("rst5 after i_0_req a", i_0_req, 0);
    drive(0, 0, 1);
    chk("rst5 after i_0_req b", i_0_req, 0);
    drive(1, 32'h87654321, 1);
    chk("rst5 new load i_0_req", i_0_req, 0);
    drive(0, 0, 1);
    chk("rst5 new beat0 i_0_req", i_0_req, 1);
    chk("rst5 new beat0 i_0_dat", i_0_dat, 8'h21);
    chk("rst5 new beat0 i_0_last", i_0_last, 0);
    drive(0, 0, 1);
    chk("rst5 new beat1", i_0_dat, 8'h43);
    drive(0, 0, 1);
    chk("rst5 new beat2", i_0_dat, 8'h65);
    drive(0, 0, 1);
    chk("rst5 new beat3", i_0_dat, 8'h87);
    chk("rst5 new beat3 last", i_0_last, 1);
    drive(0, 0, 0);
    chk("rst5 drained i_0_req", i_0_req, 0);

    // Random handshakes against a beat scoreboard.
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 9) < 7);
      rnd_check();
    end
    for (int c = 0; c < 50 && q_d.size() != 0; c++) begin
      drive(0, 0, 1);
      rnd_check();
    end
    chk("drain queue empty", q_d.size(), 0);
    drive(0, 0, 1);
    chk("drain i_0_req", i_0_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
